// File: rtl/pipe_hold_ctrl_pkg.sv
// Shared constants and state encoding for the front-end pipeline hold/flush controller.
package pipe_ctrl_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic {
    BOOT,
    RUN
  } state_t;

endpackage

// File: rtl/pipe_hold_ctrl_if.sv
// Front-end control bundle: hazard/redirect inputs, imem handshake, IF/ID register and perf counters.
interface pipe_hold_ctrl_if #(
  parameter int unsigned CNT_W = 16
);

  logic             stall_i;
  logic             flush_i;
  logic [31:0]      flush_target_i;
  logic [31:0]      imem_rdata_i;
  logic             imem_ready_i;
  logic             imem_req_o;
  logic [31:0]      pc_o;
  logic [31:0]      if_id_pc_o;
  logic [31:0]      if_id_instr_o;
  logic             if_id_valid_o;
  logic             id_ex_bubble_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output stall_i, flush_i, flush_target_i, imem_rdata_i, imem_ready_i,
    input  imem_req_o, pc_o, if_id_pc_o, if_id_instr_o, if_id_valid_o,
           id_ex_bubble_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  stall_i, flush_i, flush_target_i, imem_rdata_i, imem_ready_i,
    output imem_req_o, pc_o, if_id_pc_o, if_id_instr_o, if_id_valid_o,
           id_ex_bubble_o, stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/pipe_hold_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Owns the fetch PC and IF/ID register; holds on load-use stalls, kills on EX redirects,
// and strobes an ID/EX bubble whenever the front end cannot hand over a fresh instruction.
module pipe_hold_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_hold_ctrl_if.slave  bus
);

  state_t           state;
  logic             imem_req;
  logic [31:0]      pc;
  logic [31:0]      if_id_pc;
  logic [31:0]      if_id_instr;
  logic             if_id_valid;
  logic             run;
  logic             eff_stall;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  assign run         = (state == RUN);
  // A stall only matters when there is a real instruction in IF/ID to protect.
  assign eff_stall   = bus.stall_i & if_id_valid;
  assign redirect_pc = bus.flush_target_i & ~32'h0000_0003;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      imem_req    <= 1'b0;
      pc          <= {RESET_PC[31:2], 2'b00};
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (state == BOOT) begin
      state    <= RUN;
      imem_req <= 1'b1;
    end else begin
      if (bus.flush_i) begin
        pc          <= redirect_pc;
        if_id_pc    <= '0;
        if_id_instr <= NOP_INSTR;
        if_id_valid <= 1'b0;
      end else if (eff_stall) begin
        pc          <= pc;
      end else if (!bus.imem_ready_i) begin
        if_id_pc    <= '0;
        if_id_instr <= NOP_INSTR;
        if_id_valid <= 1'b0;
      end else begin
        if_id_pc    <= pc;
        if_id_instr <= bus.imem_rdata_i;
        if_id_valid <= 1'b1;
        pc          <= pc + PC_STEP;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (run & ~bus.flush_i & eff_stall),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (run & bus.flush_i),
    .count (flush_cnt)
  );

  assign bus.imem_req_o     = imem_req;
  assign bus.pc_o           = pc;
  assign bus.if_id_pc_o     = if_id_pc;
  assign bus.if_id_instr_o  = if_id_instr;
  assign bus.if_id_valid_o  = if_id_valid;
  assign bus.id_ex_bubble_o = run & (bus.flush_i | eff_stall);
  assign bus.stall_cnt_o    = stall_cnt;
  assign bus.flush_cnt_o    = flush_cnt;

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed bench for pipe_hold_ctrl using 2-bit counters so saturation is reachable quickly.
module tb_pipe_hold_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int unsigned CW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_hold_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_hold_ctrl #(.RESET_PC(32'h0000_0100), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // {pc, if_id_pc, if_id_instr, if_id_valid}
  logic [96:0] fe;
  assign fe = {bus.pc_o, bus.if_id_pc_o, bus.if_id_instr_o, bus.if_id_valid_o};
  logic [96:0] exp_fe;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.stall_i = 1'b0; bus.flush_i = 1'b0; bus.flush_target_i = 32'h0;
    bus.imem_ready_i = 1'b1; bus.imem_rdata_i = 32'hAAAA_0001;
    tick(); tick();
    exp_fe = {32'h100, 32'h0, NOP_INSTR, 1'b0};
    compared++; if (fe !== exp_fe) begin mismatched++; $display("FAIL reset_fe: got %h exp %h", fe, exp_fe); end
    compared++; if (bus.imem_req_o !== 1'b0) begin mismatched++; $display("FAIL reset_req: got %b exp 0", bus.imem_req_o); end
    compared++; if ({bus.stall_cnt_o, bus.flush_cnt_o} !== 4'h0) begin mismatched++; $display("FAIL reset_cnt: got %h exp 0", {bus.stall_cnt_o, bus.flush_cnt_o}); end
    bus.flush_i = 1'b1; bus.flush_target_i = 32'h5000; #1;
    compared++; if (bus.id_ex_bubble_o !== 1'b0) begin mismatched++; $display("FAIL reset_bubble: got %b exp 0", bus.id_ex_bubble_o); end
    rst_n = 1'b1; #1;
    compared++; if ({bus.imem_req_o, bus.pc_o, bus.id_ex_bubble_o} !== {1'b0, 32'h100, 1'b0}) begin
      mismatched++; $display("FAIL boot: got req=%b pc=%h bub=%b exp req=0 pc=100 bub=0", bus.imem_req_o, bus.pc_o, bus.id_ex_bubble_o); end
    tick();
    exp_fe = {32'h100, 32'h0, NOP_INSTR, 1'b0};
    compared++; if (fe !== exp_fe) begin mismatched++; $display("FAIL boot_ignore_flush: got %h exp %h", fe, exp_fe); end
    compared++; if ({bus.imem_req_o, bus.flush_cnt_o} !== {1'b1, 2'd0}) begin
      mismatched++; $display("FAIL run_req: got req=%b fcnt=%0d exp req=1 fcnt=0", bus.imem_req_o, bus.flush_cnt_o); end
    bus.flush_i = 1'b0;
    tick();
    exp_fe = {32'h104, 32'h100, 32'hAAAA_0001, 1'b1};
    compared++; if (fe !== exp_fe) begin mismatched++; $display("FAIL first_fetch: got %h exp %h", fe, exp_fe); end
  endtask

  task automatic test_stall;
    bus.imem_rdata_i = 32'hBBBB_0002; bus.stall_i = 1'b1; #1;
    compared++; if (bus.id_ex_bubble_o !== 1'b1) begin mismatched++; $display("FAIL stall_bubble: got %b exp 1", bus.id_ex_bubble_o); end
    tick();
    exp_fe = {32'h104, 32'h100, 32'hAAAA_0001, 1'b1};
    compared++; if (fe !== exp_fe) begin mismatched++; $display("FAIL stall_hold: got %h exp %h", fe, exp_fe); end
    compared++; if (bus.stall_cnt_o !== 2'd1) begin mismatched++; $display("FAIL stall_cnt: got %0d exp 1", bus.stall_cnt_o); end
    bus.stall_i = 1'b0; #1;
    compared++; if (bus.id_ex_bubble_o !== 1'b0) begin mismatched++; $display("FAIL nostall_bubble: got %b exp 0", bus.id_ex_bubble_o); end
    tick();
    exp_fe = {32'h108, 32'h104, 32'hBBBB_0002, 1'b1};
    compared++; if (fe !== exp_fe) begin mismatched++; $display("FAIL stall_resume: got %h exp %h", fe, exp_fe); end
  endtask

  task automatic test_flush_over_stall;
    bus.stall_i = 1'b1; bus.flush_i = 1'b1; bus.flush_target_i = 32'h2003; #1;
    compared++; if (bus.id_ex_bubble_o !== 1'b1) begin mismatched++; $display("FAIL flush_bubble: got %b exp 1", bus.id_ex_bubble_o); end
    tick();
    exp_fe = {32'h2000, 32'h0, NOP_INSTR, 1'b0};
    compared++; if (fe !== exp_fe) begin mismatched++; $display("FAIL flush_fe: got %h exp %h", fe, exp_fe); end
    compared++; if ({bus.flush_cnt_o, bus.stall_cnt_o} !== {2'd1, 2'd1}) begin
      mismatched++; $display("FAIL flush_cnts: got f=%0d s=%0d exp f=1 s=1", bus.flush_cnt_o, bus.stall_cnt_o); end
    bus.stall_i = 1'b0; bus.flush_i = 1'b0; bus.imem_rdata_i = 32'hCCCC_0003;
    tick();
    exp_fe = {32'h2004, 32'h2000, 32'hCCCC_0003, 1'b1};
    compared++; if (fe !== exp_fe) begin mismatched++; $display("FAIL flush_target_fetch: got %h exp %h", fe, exp_fe); end
  endtask

  task automatic test_imem_wait;
    bus.imem_ready_i = 1'b0;
    tick();
    exp_fe = {32'h2004, 32'h0, NOP_INSTR, 1'b0};
    compared++; if (fe !== exp_fe) begin mismatched++; $display("FAIL wait_bubble0: got %h exp %h", fe, exp_fe); end
    for (int i = 1; i < 3; i++) begin
      bus.stall_i = 1'b1; #1;
      compared++; if (bus.id_ex_bubble_o !== 1'b0) begin mismatched++; $display("FAIL wait_stall_bubble%0d: got %b exp 0", i, bus.id_ex_bubble_o); end
      tick();
      compared++; if ({fe, bus.stall_cnt_o} !== {exp_fe, 2'd1}) begin
        mismatched++; $display("FAIL wait_hold%0d: got %h cnt=%0d exp %h cnt=1", i, fe, bus.stall_cnt_o, exp_fe); end
    end
    bus.stall_i = 1'b0; bus.imem_ready_i = 1'b1; bus.imem_rdata_i = 32'hDDDD_0004;
    tick();
    exp_fe = {32'h2008, 32'h2004, 32'hDDDD_0004, 1'b1};
    compared++; if (fe !== exp_fe) begin mismatched++; $display("FAIL wait_resume: got %h exp %h", fe, exp_fe); end
  endtask

  task automatic test_pc_wrap;
    bus.flush_i = 1'b1; bus.flush_target_i = 32'hFFFF_FFFC;
    tick();
    exp_fe = {32'hFFFF_FFFC, 32'h0, NOP_INSTR, 1'b0};
    compared++; if ({fe, bus.flush_cnt_o} !== {exp_fe, 2'd2}) begin
      mismatched++; $display("FAIL wrap_flush: got %h cnt=%0d exp %h cnt=2", fe, bus.flush_cnt_o, exp_fe); end
    bus.flush_i = 1'b0; bus.imem_rdata_i = 32'hEEEE_0005;
    tick();
    exp_fe = {32'h0, 32'hFFFF_FFFC, 32'hEEEE_0005, 1'b1};
    compared++; if (fe !== exp_fe) begin mismatched++; $display("FAIL wrap_zero: got %h exp %h", fe, exp_fe); end
    tick();
    exp_fe = {32'h4, 32'h0, 32'hEEEE_0005, 1'b1};
    compared++; if (fe !== exp_fe) begin mismatched++; $display("FAIL wrap_after: got %h exp %h", fe, exp_fe); end
  endtask

  task automatic test_flush_saturation;
    bus.flush_i = 1'b1; bus.flush_target_i = 32'h300;
    tick();
    compared++; if (bus.flush_cnt_o !== 2'd3) begin mismatched++; $display("FAIL fsat_3: got %0d exp 3", bus.flush_cnt_o); end
    tick();
    exp_fe = {32'h300, 32'h0, NOP_INSTR, 1'b0};
    compared++; if ({fe, bus.flush_cnt_o} !== {exp_fe, 2'd3}) begin
      mismatched++; $display("FAIL fsat_hold: got %h cnt=%0d exp %h cnt=3", fe, bus.flush_cnt_o, exp_fe); end
    bus.flush_i = 1'b0;
  endtask

  task automatic test_async_reset;
    bus.flush_i = 1'b1; bus.flush_target_i = 32'h1EC;
    tick();
    bus.flush_i = 1'b0; bus.imem_rdata_i = 32'h1234_5678;
    tick();
    exp_fe = {32'h1F0, 32'h1EC, 32'h1234_5678, 1'b1};
    compared++; if (fe !== exp_fe) begin mismatched++; $display("FAIL arst_pre: got %h exp %h", fe, exp_fe); end
    bus.stall_i = 1'b1; #1;
    compared++; if (bus.id_ex_bubble_o !== 1'b1) begin mismatched++; $display("FAIL arst_pre_bubble: got %b exp 1", bus.id_ex_bubble_o); end
    rst_n = 1'b0; #1;
    exp_fe = {32'h100, 32'h0, NOP_INSTR, 1'b0};
    compared++; if (fe !== exp_fe) begin mismatched++; $display("FAIL arst_fe: got %h exp %h", fe, exp_fe); end
    compared++; if ({bus.imem_req_o, bus.id_ex_bubble_o, bus.stall_cnt_o, bus.flush_cnt_o} !== 6'b0) begin
      mismatched++; $display("FAIL arst_ctl: got req=%b bub=%b s=%0d f=%0d exp all 0",
        bus.imem_req_o, bus.id_ex_bubble_o, bus.stall_cnt_o, bus.flush_cnt_o); end
    bus.stall_i = 1'b0; #1;
    rst_n = 1'b1; #1;
    compared++; if ({bus.imem_req_o, bus.pc_o} !== {1'b0, 32'h100}) begin
      mismatched++; $display("FAIL arst_boot: got req=%b pc=%h exp req=0 pc=100", bus.imem_req_o, bus.pc_o); end
    tick();
    compared++; if ({bus.imem_req_o, fe} !== {1'b1, exp_fe}) begin
      mismatched++; $display("FAIL arst_run: got req=%b fe=%h exp req=1 fe=%h", bus.imem_req_o, fe, exp_fe); end
    bus.imem_rdata_i = 32'hAAAA_0001;
    tick();
    exp_fe = {32'h104, 32'h100, 32'hAAAA_0001, 1'b1};
    compared++; if (fe !== exp_fe) begin mismatched++; $display("FAIL arst_refetch: got %h exp %h", fe, exp_fe); end
  endtask

  task automatic test_stall_saturation;
    logic [CW-1:0] exp_seq [5];
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    bus.stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      compared++; if ({fe, bus.stall_cnt_o} !== {exp_fe, exp_seq[i]}) begin
        mismatched++; $display("FAIL ssat_%0d: got %h cnt=%0d exp %h cnt=%0d", i, fe, bus.stall_cnt_o, exp_fe, exp_seq[i]); end
    end
    bus.stall_i = 1'b0;
    tick();
    compared++; if ({bus.pc_o, bus.stall_cnt_o} !== {32'h108, 2'd3}) begin
      mismatched++; $display("FAIL ssat_resume: got pc=%h cnt=%0d exp pc=108 cnt=3", bus.pc_o, bus.stall_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_flush_over_stall();
    test_imem_wait();
    test_pc_wrap();
    test_flush_saturation();
    test_async_reset();
    test_stall_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
